// File: rtl/onehot_drain_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enc_pkg
// Purpose  : Shared constants and types for the one-hot drain encoder.
//            ENC_WIDTH / ENC_IDX_W : request vector width and index width.
//            enc_vec_t / enc_idx_t : vector and index types.
//            enc_state_t           : IDLE / DRAIN state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package enc_pkg;

  localparam int ENC_WIDTH = 8;
  localparam int ENC_IDX_W = 3;

  typedef logic [ENC_WIDTH-1:0] enc_vec_t;
  typedef logic [ENC_IDX_W-1:0] enc_idx_t;

  typedef enum logic [0:0] {
    ENC_IDLE  = 1'b0,
    ENC_DRAIN = 1'b1
  } enc_state_t;

endpackage : enc_pkg
`default_nettype wire

// File: rtl/onehot_drain_encoder_prio_enc8.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc8
// Purpose  : Combinational 8-bit priority encoder.
//            Default build: lowest set index wins (LSB first).
//            With ENC_MSB_FIRST_EN defined: highest set index wins.
// Ports    : i_vec    - request vector
//            o_idx    - index of the winning set bit (0 when i_vec == 0)
//            o_single - exactly one bit of i_vec is set
// Macro    : ENC_MSB_FIRST_EN selects MSB-first priority.
// Revision : 1.0 - initial release
// ============================================================================
module prio_enc8
  import enc_pkg::*;
(
  input  logic [ENC_WIDTH-1:0] i_vec,
  output logic [ENC_IDX_W-1:0] o_idx,
  output logic                 o_single
);

  // The loop scans away from the winning end so the last hit written is
  // the highest-priority bit.
  always_comb begin
    o_idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < ENC_WIDTH; i++) begin
      if (i_vec[i]) o_idx = enc_idx_t'(i);
    end
`else
    for (int i = ENC_WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = enc_idx_t'(i);
    end
`endif
  end

  // Clearing the lowest set bit leaves zero only for a one-hot vector.
  assign o_single = (i_vec != '0) && ((i_vec & (i_vec - enc_vec_t'(1))) == '0);

endmodule : prio_enc8
`default_nettype wire

// File: rtl/onehot_drain_encoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_drain_encoder
// Purpose  : Accepts a multi-hot request vector and emits the index of each
//            set bit, one per output handshake, in priority order.
// Ports    : clk, rst_n (sync active-low)
//            in_valid / in_ready / in_vec        - request vector input
//            out_valid / out_ready / out_idx     - index output
//            out_last                            - final index of a vector
//            zero_err                            - all-zero vector dropped
// Macro    : ENC_MSB_FIRST_EN reverses priority (highest index first).
// Revision : 1.0 - initial release
// ============================================================================
module onehot_drain_encoder
  import enc_pkg::*;
#(
  parameter int WIDTH = ENC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_idx,
  output logic             out_last,
  output logic             zero_err
);

  enc_state_t r_state;
  enc_vec_t   r_pending;
  logic       r_zero_err;

  enc_idx_t   w_idx;
  logic       w_single;
  logic       w_accept;
  logic       w_out_hs;
  enc_vec_t   w_clr_mask;

  prio_enc8 u_prio (
    .i_vec    (r_pending),
    .o_idx    (w_idx),
    .o_single (w_single)
  );

  assign out_valid = (r_state == ENC_DRAIN);
  assign out_idx   = w_idx;
  assign out_last  = w_single;
  assign zero_err  = r_zero_err;

  // Accept in the same cycle as the final handshake so vectors run gapless.
  assign in_ready   = (r_state == ENC_IDLE) || (out_ready && w_single);
  assign w_accept   = in_valid && in_ready;
  assign w_out_hs   = out_valid && out_ready;
  assign w_clr_mask = enc_vec_t'(1) << w_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ENC_IDLE;
      r_pending  <= '0;
      r_zero_err <= 1'b0;
    end else begin
      r_zero_err <= w_accept && (in_vec == '0);
      if (w_accept) begin
        // An accept only happens with nothing left to drain afterwards, so
        // a zero vector leaves the block idle with pending cleared.
        r_pending <= in_vec;
        r_state   <= (in_vec != '0) ? ENC_DRAIN : ENC_IDLE;
      end else if (w_out_hs) begin
        r_pending <= r_pending & ~w_clr_mask;
        r_state   <= w_single ? ENC_IDLE : ENC_DRAIN;
      end
    end
  end

endmodule : onehot_drain_encoder
`default_nettype wire

// File: tb/tb_onehot_drain_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_drain_encoder
// Purpose  : Self-checking bench for onehot_drain_encoder. A queue of the
//            indices still owed is the reference: filled from the set bits
//            of each accepted vector, popped on each output handshake.
// Macro    : ENC_MSB_FIRST_EN (must match the RTL build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_drain_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       zero_err;

  int n_vec;
  int n_cmp;
  int n_err;

  int   q[$];   // indices still to be emitted, in emission order
  logic zf;     // expected zero_err for the coming cycle

  onehot_drain_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .zero_err  (zero_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic fill(input logic [7:0] vec);
    q.delete();
`ifdef ENC_MSB_FIRST_EN
    for (int i = 7; i >= 0; i--) if (vec[i]) q.push_back(i);
`else
    for (int i = 0; i < 8; i++) if (vec[i]) q.push_back(i);
`endif
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs before the edge, then
  // advance the reference across the edge.
  task automatic step(input logic rn, input logic v, input logic [7:0] vec, input logic rdy);
    logic ev, eir, hs, acc;
    rst_n = rn; in_valid = v; in_vec = vec; out_ready = rdy;
    @(negedge clk);
    ev  = (q.size() != 0);
    eir = !ev || (rdy && q.size() == 1);
    chk("out_valid", {7'b0, out_valid}, {7'b0, ev});
    chk("out_idx",   {5'b0, out_idx},   ev ? 8'(q[0]) : 8'h00);
    chk("out_last",  {7'b0, out_last},  {7'b0, (q.size() == 1)});
    chk("in_ready",  {7'b0, in_ready},  {7'b0, eir});
    chk("zero_err",  {7'b0, zero_err},  {7'b0, zf});
    n_vec++;
    if (!rn) begin
      q.delete();
      zf = 1'b0;
    end else begin
      hs  = ev && rdy;
      acc = v && eir;
      if (hs) void'(q.pop_front());
      zf = acc && (vec == 8'h00);
      if (acc && vec != 8'h00) fill(vec);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       rn, v, rdy;
    logic [7:0] vec;
    n_vec = 0; n_cmp = 0; n_err = 0; zf = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();

    // Reset state after release
    step(1, 0, 8'h00, 1);

    // Multi-hot drain with out_ready high
    step(1, 1, 8'b1010_0100, 1);
    repeat (3) step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);

    // Backpressure for 4 cycles, then release
    step(1, 1, 8'h81, 0);
    repeat (4) step(1, 0, 8'h00, 0);
    repeat (2) step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);

    // All-zero vector while idle
    step(1, 1, 8'h00, 1);
    repeat (2) step(1, 0, 8'h00, 1);

    // Back-to-back vectors offered continuously
    step(1, 1, 8'h10, 1);
    step(1, 1, 8'h03, 1);
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);

    // Reset mid-drain of 8'hFF after four indices have gone out
    step(1, 1, 8'hFF, 1);
    repeat (4) step(1, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    repeat (3) step(1, 0, 8'h00, 1);

    // Randomised traffic including zero, one-hot and multi-hot vectors
    for (int k = 0; k < 400; k++) begin
      rn  = ($urandom_range(0, 59) != 0);
      v   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       vec = 8'h00;
        1:       vec = 8'h01 << $urandom_range(0, 7);
        default: vec = 8'($urandom);
      endcase
      step(rn, v, vec, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_onehot_drain_encoder
`default_nettype wire
